fpu_normalize_pack: RTL and testbench

- Post-adder stage of the single-precision add/sub path. Sits directly downstream of the CLA mantissa adder.
- Takes the 24-bit adder sum, its carry-out, the larger operand's biased exponent and the result sign.
- Normalises the sum iteratively: right shift by 1 on carry; left shifts of 4 or 1 per cycle on cancellation.
- Packs an IEEE-754 single word with overflow/underflow/zero flags, behind a valid/ready handshake.

---
 rtl/fpu_normalize_pack.sv | 181 ++++++++++++++++++
 tb/tb_fpu_normalize_pack.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_normalize_pack.sv
// Post-adder normalise-and-pack stage of the single-precision add/sub path.
// Carry is folded in with one right shift; cancellation is removed by iterative coarse/fine left shifts.
module fpu_normalize_pack #(
  parameter int FORMAT_LENGTH             = 32,
  parameter int EXPONENT_LENGTH           = 8,
  parameter int FRACTION_LENGTH           = 23,
  parameter int NORMALIZE_MANTISSA_LENGTH = 24,
  parameter int COARSE_SHIFT              = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] sum_in,
  input  logic                                 cout_in,
  input  logic [EXPONENT_LENGTH-1:0]           exp_in,
  input  logic                                 sign_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [FORMAT_LENGTH-1:0]             fp_out,
  output logic                                 overflow,
  output logic                                 underflow,
  output logic                                 zero
);

  localparam int ML = NORMALIZE_MANTISSA_LENGTH;
  localparam int EL = EXPONENT_LENGTH;
  localparam int FL = FRACTION_LENGTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_PACK = 2'd2;

  localparam logic [EL-1:0] EXP_ZERO   = {EL{1'b0}};
  localparam logic [EL-1:0] EXP_ONE    = EL'(1);
  localparam logic [EL-1:0] EXP_MAX    = {EL{1'b1}};
  localparam logic [EL-1:0] EXP_COARSE = EL'(COARSE_SHIFT);
  localparam logic [FL-1:0] FRAC_ZERO  = {FL{1'b0}};
  localparam logic [ML-1:0] MANT_ZERO  = {ML{1'b0}};

  function automatic logic [FORMAT_LENGTH-1:0] pack_word(input logic s,
                                                         input logic [EL-1:0] e,
                                                         input logic [FL-1:0] f);
    return {s, e, f};
  endfunction

  logic [1:0]               state_q, state_d;
  logic [ML-1:0]            mant_q, mant_d;
  logic [EL-1:0]            exp_q, exp_d;
  logic                     sign_q, sign_d;
  logic [FORMAT_LENGTH-1:0] fp_q, fp_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     zero_q, zero_d;
  logic                     out_valid_q, out_valid_d;

  logic [EL-1:0] exp_inc_s;
  logic [ML-1:0] cout_mant_s;

  assign exp_inc_s   = exp_in + EXP_ONE;
  assign cout_mant_s = {1'b1, sum_in[ML-1:1]};

  // Next-state, datapath and output-register decode
  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    fp_d        = fp_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    zero_d      = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = sign_in;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          zero_d = 1'b0;
          if (cout_in) begin
            mant_d  = cout_mant_s;
            exp_d   = exp_inc_s;
            state_d = ST_PACK;
            if (exp_inc_s == EXP_MAX) begin
              fp_d  = pack_word(sign_in, EXP_MAX, FRAC_ZERO);
              ovf_d = 1'b1;
            end else begin
              fp_d  = pack_word(sign_in, exp_inc_s, cout_mant_s[FL-1:0]);
            end
          end else if (sum_in == MANT_ZERO) begin
            mant_d  = sum_in;
            exp_d   = exp_in;
            fp_d    = {FORMAT_LENGTH{1'b0}};
            zero_d  = 1'b1;
            state_d = ST_PACK;
          end else if (sum_in[ML-1]) begin
            mant_d  = sum_in;
            exp_d   = exp_in;
            fp_d    = pack_word(sign_in, exp_in, sum_in[FL-1:0]);
            state_d = ST_PACK;
          end else begin
            mant_d  = sum_in;
            exp_d   = exp_in;
            state_d = ST_NORM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NORM: begin
        if (mant_q[ML-1]) begin
          fp_d    = pack_word(sign_q, exp_q, mant_q[FL-1:0]);
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = ST_PACK;
        end else if ((mant_q[ML-1 -: COARSE_SHIFT] == {COARSE_SHIFT{1'b0}}) &&
                     (exp_q > EXP_COARSE)) begin
          mant_d  = {mant_q[ML-1-COARSE_SHIFT:0], {COARSE_SHIFT{1'b0}}};
          exp_d   = exp_q - EXP_COARSE;
          state_d = ST_NORM;
        end else if (exp_q > EXP_ONE) begin
          mant_d  = {mant_q[ML-2:0], 1'b0};
          exp_d   = exp_q - EXP_ONE;
          state_d = ST_NORM;
        end else begin
          // Exponent floor reached before the hidden bit: emit a denormal
          fp_d    = pack_word(sign_q, EXP_ZERO, mant_q[FL-1:0]);
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          zero_d  = 1'b0;
          state_d = ST_PACK;
        end
      end
      ST_PACK: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    out_valid_d = (state_d == ST_PACK);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mant_q      <= MANT_ZERO;
      exp_q       <= EXP_ZERO;
      sign_q      <= 1'b0;
      fp_q        <= {FORMAT_LENGTH{1'b0}};
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      fp_q        <= fp_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign fp_out    = fp_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_fpu_normalize_pack.sv
// Self-checking bench for fpu_normalize_pack: directed vector table, hand-written
// backpressure/reset sequences, and random operands against an arithmetic reference model.
module tb_fpu_normalize_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] sum_in;
  logic        cout_in;
  logic [7:0]  exp_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_out;
  logic        overflow;
  logic        underflow;
  logic        zero;

  int n_checks = 0;
  int n_err    = 0;

  fpu_normalize_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .exp_in    (exp_in),
    .sign_in   (sign_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_out    (fp_out),
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] sum;
    logic        cout;
    logic [7:0]  exp;
    logic        sign;
    logic [31:0] fp;
    logic        ovf;
    logic        unf;
    logic        zro;
    int          lat;
  } vec_t;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: value = sum * 2^(exp-150); left-normalise as far as the exponent floor of 1 allows.
  function automatic void ref_model(input logic [23:0] s, input logic c, input logic [7:0] e,
                                    input logic sg, output logic [31:0] fp, output logic o,
                                    output logic u, output logic z, output int lat);
    int p, k, ee, n, sh;
    logic [23:0] m;
    o = 1'b0; u = 1'b0; z = 1'b0; lat = 1;
    if (c) begin
      if (int'(e) + 1 == 255) begin
        fp = {sg, 8'hFF, 23'h0};
        o  = 1'b1;
      end else begin
        fp = {sg, 8'(int'(e) + 1), s[23:1]};
      end
    end else if (s == 24'h0) begin
      fp = 32'h0;
      z  = 1'b1;
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (s[i]) p = i;
      k = 23 - p;
      if (k <= int'(e) - 1) begin
        m  = s << k;
        fp = {sg, 8'(int'(e) - k), m[22:0]};
      end else begin
        sh = int'(e) - 1;
        m  = s << sh;
        fp = {sg, 8'h00, m[22:0]};
        u  = 1'b1;
      end
      if (k > 0) begin
        // shift cycles: steps of 4 while >=4 remain and exponent allows, else steps of 1
        n = 0; ee = int'(e);
        while (k > 0) begin
          if (k >= 4 && ee > 4) begin k -= 4; ee -= 4; end
          else if (ee > 1)      begin k -= 1; ee -= 1; end
          else break;
          n++;
        end
        lat = 2 + n;
      end
    end
  endfunction

  // Apply one operation, check latency/result, optionally hold backpressure, check return to IDLE.
  task automatic run_op(input logic [23:0] s, input logic c, input logic [7:0] e, input logic sg,
                        input logic [31:0] efp, input logic eo, input logic eu, input logic ez,
                        input int elat, input int hold, input string name);
    int lat;
    bit busy_ok;
    bit timed_out;
    @(negedge clk);
    chk(in_ready == 1'b1, {name, ".ready_idle"}, in_ready, 1);
    sum_in = s; cout_in = c; exp_in = e; sign_in = sg; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1; busy_ok = 1'b1; timed_out = 1'b0;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) busy_ok = 1'b0;
      if (lat >= 40) begin timed_out = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    chk(!timed_out, {name, ".timeout"}, lat, elat);
    chk(lat == elat, {name, ".latency"}, lat, elat);
    chk(busy_ok, {name, ".ready_low_norm"}, busy_ok, 1);
    chk(in_ready == 1'b0, {name, ".ready_low_pack"}, in_ready, 0);
    chk(fp_out == efp, {name, ".fp_out"}, fp_out, efp);
    chk({overflow, underflow, zero} == {eo, eu, ez}, {name, ".flags"},
        {overflow, underflow, zero}, {eo, eu, ez});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk(out_valid && !in_ready && fp_out == efp && {overflow, underflow, zero} == {eo, eu, ez},
          {name, ".hold_stable"}, fp_out, efp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(out_valid == 1'b0 && in_ready == 1'b1, {name, ".release"}, {out_valid, in_ready}, 2'b01);
    if (timed_out) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end
  endtask

  vec_t vecs[8];
  logic [31:0] rfp;
  logic ro, ru, rz;
  int rlat;

  initial begin
    vecs[0] = '{24'h000000, 1'b1, 8'h7F, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{24'hC00000, 1'b0, 8'h7F, 1'b1, 32'hBFC00000, 1'b0, 1'b0, 1'b0, 1};
    vecs[2] = '{24'h000001, 1'b0, 8'h7F, 1'b0, 32'h34000000, 1'b0, 1'b0, 1'b0, 10};
    vecs[3] = '{24'h000000, 1'b0, 8'h7F, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
    vecs[4] = '{24'h000100, 1'b0, 8'h03, 1'b0, 32'h00000400, 1'b0, 1'b1, 1'b0, 4};
    vecs[5] = '{24'h000010, 1'b0, 8'h05, 1'b1, 32'h80000100, 1'b0, 1'b1, 1'b0, 3};
    vecs[6] = '{24'h000010, 1'b0, 8'h04, 1'b0, 32'h00000080, 1'b0, 1'b1, 1'b0, 5};
    vecs[7] = '{24'h400000, 1'b0, 8'h02, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0, 3};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sum_in = 24'h0; cout_in = 1'b0; exp_in = 8'h01; sign_in = 1'b0;
    #3;
    chk(in_ready == 1'b1 && out_valid == 1'b0, "reset.handshake", {in_ready, out_valid}, 2'b10);
    chk(fp_out == 32'h0 && {overflow, underflow, zero} == 3'b000, "reset.outputs", fp_out, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].sum, vecs[i].cout, vecs[i].exp, vecs[i].sign, vecs[i].fp,
             vecs[i].ovf, vecs[i].unf, vecs[i].zro, vecs[i].lat, 0, $sformatf("vec%0d", i));

    // Overflow with three cycles of backpressure
    run_op(24'h800000, 1'b1, 8'hFE, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1, 3, "ovf_bp");

    // Asynchronous reset in the middle of a deep normalisation
    @(negedge clk);
    sum_in = 24'h000001; cout_in = 1'b0; exp_in = 8'h7F; sign_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk(in_ready == 1'b1 && out_valid == 1'b0, "midreset.handshake", {in_ready, out_valid}, 2'b10);
    chk(fp_out == 32'h0 && {overflow, underflow, zero} == 3'b000, "midreset.outputs", fp_out, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(24'h000000, 1'b1, 8'h7F, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 1, 0, "after_reset");

    // Random operands against the reference model
    for (int t = 0; t < 150; t++) begin
      logic [23:0] s;
      logic [31:0] r;
      logic c, sg;
      logic [7:0] e;
      int lz;
      lz = $urandom_range(0, 24);
      r  = $urandom;
      s  = (lz == 24) ? 24'h0 : ((r[23:0] | 24'h800000) >> lz);
      c  = ($urandom_range(0, 3) == 0);
      sg = r[31];
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom_range(1, 8));
        1:       e = 8'hFE;
        default: e = 8'($urandom_range(1, 254));
      endcase
      ref_model(s, c, e, sg, rfp, ro, ru, rz, rlat);
      run_op(s, c, e, sg, rfp, ro, ru, rz, rlat, $urandom_range(0, 2), $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
